// File: rtl/bram_burst_reader.sv
// Burst reader over an internal true dual-port BRAM: programmable base/stride/length,
// valid/ready stream out on port 0, memory load through port 1 at any time.
module bram_burst_reader #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 7,
    parameter int MEM_SIZE = 100,
    parameter int LWIDTH   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [AWIDTH-1:0] base_i,
    input  logic [AWIDTH-1:0] stride_i,
    input  logic [LWIDTH-1:0] len_i,
    input  logic              wr_en_i,
    input  logic [AWIDTH-1:0] wr_addr_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DWIDTH-1:0] m_data_o,
    output logic              m_last_o,
    output logic              idle_o,
    output logic              run_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [AWIDTH:0] MEM_SIZE_W = (AWIDTH+1)'(MEM_SIZE);

    state_t state_reg, state_next;

    logic [DWIDTH-1:0] mem [0:MEM_SIZE-1];
    logic [DWIDTH-1:0] rd_data_reg;
    logic [DWIDTH-1:0] skid_reg;
    logic              rd_vld_reg;
    logic              skid_vld_reg;
    logic              err_reg;
    logic [AWIDTH-1:0] addr_reg;
    logic [AWIDTH-1:0] stride_reg;
    logic [LWIDTH-1:0] len_reg;
    logic [LWIDTH-1:0] issued_reg;
    logic [LWIDTH-1:0] accepted_reg;

    logic              args_ok;
    logic              start_ok;
    logic              issue;
    logic              pop;
    logic              is_last;
    logic [AWIDTH:0]   addr_sum;
    logic [AWIDTH:0]   addr_wrap;
    logic [AWIDTH-1:0] addr_next;

    assign args_ok  = ({1'b0, base_i} < MEM_SIZE_W) && ({1'b0, stride_i} < MEM_SIZE_W);
    assign start_ok = (state_reg == IDLE) && start_i && args_ok;

    // The BRAM output register and the skid register together form the
    // 2-entry buffer; a read lands in it on the edge after issue, so the
    // credit check reduces to "not both entries occupied".
    assign issue = (state_reg == RUN) && (issued_reg < len_reg) && !(rd_vld_reg && skid_vld_reg);
    assign m_valid_o = rd_vld_reg | skid_vld_reg;
    assign pop       = m_valid_o & m_ready_i;
    assign is_last   = (accepted_reg == len_reg - LWIDTH'(1));
    assign m_last_o  = m_valid_o & is_last;

    always_comb begin
        m_data_o = '0;
        if (skid_vld_reg)
            m_data_o = skid_reg;
        else if (rd_vld_reg)
            m_data_o = rd_data_reg;
    end

    always_comb begin
        addr_sum  = {1'b0, addr_reg} + {1'b0, stride_reg};
        addr_wrap = addr_sum;
        if (addr_sum >= MEM_SIZE_W)
            addr_wrap = addr_sum - MEM_SIZE_W;
        addr_next = addr_wrap[AWIDTH-1:0];
    end

    assign idle_o = (state_reg == IDLE);
    assign run_o  = (state_reg == RUN);
    assign done_o = (state_reg == DONE);
    assign err_o  = err_reg;

    // Port 1 write and port 0 read share an edge; non-blocking update gives read-first.
    always_ff @(posedge clk) begin
        if (wr_en_i && ({1'b0, wr_addr_i} < MEM_SIZE_W))
            mem[wr_addr_i] <= wr_data_i;
        if (issue)
            rd_data_reg <= mem[addr_reg];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start_ok) state_next = (len_i == '0) ? DONE : RUN;
            RUN:  if (pop && is_last) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg      <= 1'b0;
            rd_vld_reg   <= 1'b0;
            skid_vld_reg <= 1'b0;
            skid_reg     <= '0;
            addr_reg     <= '0;
            stride_reg   <= '0;
            len_reg      <= '0;
            issued_reg   <= '0;
            accepted_reg <= '0;
        end else begin
            err_reg <= (state_reg == IDLE) && start_i && !args_ok;
            if (start_ok) begin
                addr_reg     <= base_i;
                stride_reg   <= stride_i;
                len_reg      <= len_i;
                issued_reg   <= '0;
                accepted_reg <= '0;
            end
            if (issue) begin
                addr_reg   <= addr_next;
                issued_reg <= issued_reg + LWIDTH'(1);
            end
            if (pop)
                accepted_reg <= accepted_reg + LWIDTH'(1);

            // Older word moves to the skid slot when a new read would overwrite it unconsumed.
            if (pop && skid_vld_reg) begin
                skid_vld_reg <= 1'b0;
            end else if (issue && rd_vld_reg && !pop) begin
                skid_vld_reg <= 1'b1;
                skid_reg     <= rd_data_reg;
            end

            if (issue)
                rd_vld_reg <= 1'b1;
            else if (pop && !skid_vld_reg)
                rd_vld_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bram_burst_reader.sv
// Self-checking bench for bram_burst_reader: directed bursts plus randomized
// bursts/backpressure checked against an array-based memory model.
module tb_bram_burst_reader;

    localparam int DWIDTH   = 32;
    localparam int AWIDTH   = 7;
    localparam int MEM_SIZE = 100;
    localparam int LWIDTH   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic [AWIDTH-1:0] base_i = '0;
    logic [AWIDTH-1:0] stride_i = '0;
    logic [LWIDTH-1:0] len_i = '0;
    logic              wr_en_i = 1'b0;
    logic [AWIDTH-1:0] wr_addr_i = '0;
    logic [DWIDTH-1:0] wr_data_i = '0;
    logic              m_valid_o;
    logic              m_ready_i = 1'b1;
    logic [DWIDTH-1:0] m_data_o;
    logic              m_last_o;
    logic              idle_o, run_o, done_o, err_o;

    logic [DWIDTH-1:0] model_mem [0:MEM_SIZE-1];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_burst_reader #(
        .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MEM_SIZE(MEM_SIZE), .LWIDTH(LWIDTH)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_i(base_i), .stride_i(stride_i),
        .len_i(len_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o),
        .idle_o(idle_o), .run_o(run_o), .done_o(done_o), .err_o(err_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_write(input int addr, input logic [31:0] data);
        wr_en_i   = 1'b1;
        wr_addr_i = AWIDTH'(addr);
        wr_data_i = data;
        model_mem[addr] = data;
        step();
        wr_en_i = 1'b0;
    endtask

    function automatic logic pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1 && cyc <= 4) return (cyc == 1 || cyc == 4);
        return 1'($urandom_range(0, 1));
    endfunction

    // One burst: start in cycle T (cyc 0), wr_cyc = cycle to overwrite mem[3] with 0xDEAD,
    // mid_start = cycle to pulse a stray start while running (-1 disables either).
    task automatic burst(input int base, input int stride, input int len, input int rmode,
                         input int wr_cyc, input int mid_start);
        logic [31:0] exp_q[$];
        logic [31:0] prev_data;
        logic        prev_stall;
        int a, k, cyc, first_v, done_c, last_c;
        a = base;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(model_mem[a]);
            a = (a + stride) % MEM_SIZE;
        end
        start_i  = 1'b1;
        base_i   = AWIDTH'(base);
        stride_i = AWIDTH'(stride);
        len_i    = LWIDTH'(len);
        step();
        start_i = 1'b0;
        cyc = 1;
        check_eq("run_at_t1", {31'd0, run_o}, {31'd0, len > 0});
        k = 0; first_v = -1; done_c = -1; last_c = -1;
        prev_stall = 1'b0; prev_data = '0;
        while (done_c < 0 && cyc < 1000) begin
            m_ready_i = pick_ready(rmode, cyc);
            wr_en_i   = 1'b0;
            if (cyc == wr_cyc) begin
                wr_en_i   = 1'b1;
                wr_addr_i = AWIDTH'(3);
                wr_data_i = 32'hDEAD;
                model_mem[3] = 32'hDEAD;
            end
            start_i = (cyc == mid_start);
            if (cyc == mid_start) begin
                base_i = AWIDTH'(50); stride_i = AWIDTH'(7); len_i = LWIDTH'(3);
            end
            if (prev_stall) begin
                check_eq("stall_valid", {31'd0, m_valid_o}, 32'd1);
                check_eq("stall_data", m_data_o, prev_data);
            end
            if (done_o) done_c = cyc;
            if (m_valid_o) begin
                if (first_v < 0) first_v = cyc;
                if (m_ready_i) begin
                    if (k < len) begin
                        check_eq("beat_data", m_data_o, exp_q[k]);
                        check_eq("beat_last", {31'd0, m_last_o}, {31'd0, k == len - 1});
                    end else begin
                        check_eq("extra_beat", k, len - 1);
                    end
                    k++;
                    last_c = cyc;
                end
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_data  = m_data_o;
            step();
            cyc++;
        end
        start_i = 1'b0; wr_en_i = 1'b0; m_ready_i = 1'b1;
        check_eq("done_seen", {31'd0, done_c >= 0}, 32'd1);
        check_eq("beat_count", k, len);
        if (len > 0) check_eq("done_after_last", done_c, last_c + 1);
        else begin
            check_eq("len0_done_cyc", done_c, 1);
            check_eq("len0_no_valid", first_v, -1);
        end
        if (rmode == 0 && len > 0) begin
            check_eq("first_valid_cyc", first_v, 2);
            check_eq("done_cyc", done_c, len + 2);
        end
        check_eq("idle_after", {31'd0, idle_o}, 32'd1);
        check_eq("valid_after", {31'd0, m_valid_o}, 32'd0);
        $display("burst base=%0d stride=%0d len=%0d mode=%0d beats=%0d done_cyc=%0d",
                 base, stride, len, rmode, k, done_c);
    endtask

    task automatic reject(input int base, input int stride);
        start_i = 1'b1; base_i = AWIDTH'(base); stride_i = AWIDTH'(stride); len_i = 8'd4;
        step();
        start_i = 1'b0;
        check_eq("err_pulse", {31'd0, err_o}, 32'd1);
        check_eq("err_idle", {31'd0, idle_o}, 32'd1);
        check_eq("err_no_run", {31'd0, run_o}, 32'd0);
        check_eq("err_no_valid", {31'd0, m_valid_o}, 32'd0);
        step();
        check_eq("err_cleared", {31'd0, err_o}, 32'd0);
        check_eq("err_idle2", {31'd0, idle_o}, 32'd1);
        $display("reject base=%0d stride=%0d", base, stride);
    endtask

    initial begin
        step(); step();
        check_eq("rst_idle", {31'd0, idle_o}, 32'd1);
        check_eq("rst_run", {31'd0, run_o}, 32'd0);
        check_eq("rst_done", {31'd0, done_o}, 32'd0);
        check_eq("rst_err", {31'd0, err_o}, 32'd0);
        check_eq("rst_valid", {31'd0, m_valid_o}, 32'd0);
        check_eq("rst_last", {31'd0, m_last_o}, 32'd0);
        check_eq("rst_data", m_data_o, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < MEM_SIZE; i++) mem_write(i, 32'(i + 100));

        burst(0, 1, 5, 0, -1, -1);
        burst(97, 2, 4, 0, -1, -1);
        burst(10, 3, 8, 1, -1, -1);
        burst(20, 1, 6, 0, -1, 3);
        burst(5, 1, 0, 0, -1, -1);
        burst(42, 0, 3, 0, -1, -1);
        reject(100, 1);
        reject(5, 100);
        burst(99, 99, 4, 0, -1, -1);

        // write in the cycle the read of mem[3] is issued, then re-read it
        burst(0, 1, 5, 0, 4, -1);
        burst(2, 1, 3, 0, -1, -1);

        // reset after three beats have transferred
        start_i = 1'b1; base_i = 7'd10; stride_i = 7'd1; len_i = 8'd8; m_ready_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        check_eq("pre_rst_beat0", m_data_o, model_mem[10]);
        step(); step(); step();
        rst = 1'b1;
        step();
        check_eq("mid_rst_idle", {31'd0, idle_o}, 32'd1);
        check_eq("mid_rst_valid", {31'd0, m_valid_o}, 32'd0);
        check_eq("mid_rst_run", {31'd0, run_o}, 32'd0);
        rst = 1'b0;
        $display("reset mid-burst after 3 beats");
        step();
        burst(10, 1, 5, 0, -1, -1);

        for (int n = 0; n < 14; n++) begin
            for (int w = 0; w < 3; w++) mem_write($urandom_range(0, MEM_SIZE - 1), $urandom);
            burst($urandom_range(0, MEM_SIZE - 1), $urandom_range(0, MEM_SIZE - 1),
                  (n % 7 == 6) ? 0 : $urandom_range(1, 20), $urandom_range(0, 2), -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
